// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared types and constants for the instruction fetch unit
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_KEEP     = 2'd0,
        PC_INC      = 2'd1,
        PC_REDIRECT = 2'd2,
        PC_LATCHED  = 2'd3
    } pc_sel_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/instruction_fetch_pc_reg.sv
// rtl/instruction_fetch_pc_reg.sv - program counter with next-pc mux and latched redirect target
module instruction_fetch_pc_reg
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  pc_sel_e     i_pc_sel,
    input  logic        i_latch_en,
    input  logic [31:0] i_target,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;
    logic [31:0] r_target;
    logic [31:0] w_pc_next;

    // Select the next fetch address: hold, sequential, fresh redirect or target saved while draining
    always_comb begin
        w_pc_next = r_pc;
        case (i_pc_sel)
            PC_INC:      w_pc_next = r_pc + 32'd4;
            PC_REDIRECT: w_pc_next = i_target;
            PC_LATCHED:  w_pc_next = r_target;
            default:     w_pc_next = r_pc;
        endcase
    end

    // PC and the pending redirect target; the target register is only loaded while a fetch must drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= word_align(RESET_PC);
            r_target <= word_align(RESET_PC);
        end else begin
            r_pc <= w_pc_next;
            if (i_latch_en) begin
                r_target <= i_target;
            end
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-outstanding instruction fetch with redirect flush
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        instr_accept,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign
);

    fetch_state_e r_state;
    logic         r_imem_req;
    logic [31:0]  r_instruction;
    logic [31:0]  r_instr_pc;
    logic         r_instr_valid;
    logic         r_misalign;

    logic [31:0]  w_pc;
    logic [31:0]  w_target;
    logic         w_done;
    pc_sel_e      w_pc_sel;
    logic         w_latch_en;

    assign w_done   = r_imem_req & imem_ready;
    assign w_target = word_align(redirect_pc);

    // Decide how the PC moves this cycle; a redirect always wins over accept or completion
    always_comb begin
        w_pc_sel   = PC_KEEP;
        w_latch_en = 1'b0;
        case (r_state)
            ST_FETCH, ST_DRAIN: begin
                if (redirect_valid) begin
                    // The in-flight request cannot be retracted, so park the target until it completes
                    if (w_done) begin
                        w_pc_sel = PC_REDIRECT;
                    end else begin
                        w_latch_en = 1'b1;
                    end
                end else if (w_done && r_state == ST_DRAIN) begin
                    w_pc_sel = PC_LATCHED;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    w_pc_sel = PC_REDIRECT;
                end else if (instr_accept) begin
                    w_pc_sel = PC_INC;
                end
            end
            default: w_pc_sel = PC_KEEP;
        endcase
    end

    instruction_fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_pc_sel   (w_pc_sel),
        .i_latch_en (w_latch_en),
        .i_target   (w_target),
        .o_pc       (w_pc)
    );

    // Fetch sequencing with registered request and presented-instruction outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_FETCH;
            r_imem_req    <= 1'b1;
            r_instruction <= NOP_INSTR;
            r_instr_pc    <= 32'h0;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (redirect_valid) begin
                        if (!w_done) begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (w_done) begin
                        r_instruction <= imem_rdata;
                        r_instr_pc    <= w_pc;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid || instr_accept) begin
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        r_state       <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    // Data returning here belongs to the flushed path and is dropped
                    if (w_done) begin
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state       <= ST_FETCH;
                    r_imem_req    <= 1'b1;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky record of any redirect to a non-word-aligned target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = w_pc;
    assign instruction = r_instruction;
    assign instr_valid = r_instr_valid;
    assign instr_pc    = r_instr_pc;
    assign misalign    = r_misalign;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ready;
    logic        instr_accept;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        imem_req,    imem_req_b;
    logic [31:0] imem_addr,   imem_addr_b;
    logic [31:0] imem_rdata,  imem_rdata_b;
    logic [31:0] instruction, instruction_b;
    logic        instr_valid, instr_valid_b;
    logic [31:0] instr_pc,    instr_pc_b;
    logic        misalign,    misalign_b;

    int n_checks = 0;
    int n_err    = 0;

    // reference state: either holding a presented word, or waiting on one request
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_mis;
    logic        m_doomed;
    logic [31:0] m_tgt;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    assign imem_rdata   = mem_word(imem_addr);
    assign imem_rdata_b = mem_word(imem_addr_b);

    instruction_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .instruction    (instruction),
        .instr_valid    (instr_valid),
        .instr_accept   (instr_accept),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign       (misalign)
    );

    instruction_fetch #(.RESET_PC(32'hBFC0_0000)) dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req_b),
        .imem_addr      (imem_addr_b),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata_b),
        .instruction    (instruction_b),
        .instr_valid    (instr_valid_b),
        .instr_accept   (instr_accept),
        .instr_pc       (instr_pc_b),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign       (misalign_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_pc     = 32'h0;
        m_instr  = 32'h0;
        m_ipc    = 32'h0;
        m_mis    = 1'b0;
        m_doomed = 1'b0;
        m_tgt    = 32'h0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        tgt = redirect_pc & 32'hFFFF_FFFC;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (redirect_valid && redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
            if (m_valid) begin
                if (redirect_valid) begin
                    m_valid = 1'b0;
                    m_pc    = tgt;
                end else if (instr_accept) begin
                    m_valid = 1'b0;
                    m_pc    = m_pc + 32'd4;
                end
            end else begin
                if (redirect_valid) begin
                    m_doomed = 1'b1;
                    m_tgt    = tgt;
                end
                if (imem_ready) begin
                    if (m_doomed) begin
                        m_pc     = m_tgt;
                        m_doomed = 1'b0;
                    end else begin
                        m_valid = 1'b1;
                        m_instr = mem_word(m_pc);
                        m_ipc   = m_pc;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("imem_req",    32'(imem_req),    32'(!m_valid));
        chk("imem_addr",   imem_addr,        m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("instruction", instruction,      m_instr);
        chk("instr_pc",    instr_pc,         m_ipc);
        chk("misalign",    32'(misalign),    32'(m_mis));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        imem_ready     = 1'b0;
        instr_accept   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);

        // zero-wait memory, always accepting
        rst_n        = 1'b1;
        imem_ready   = 1'b1;
        instr_accept = 1'b1;
        check_all();
        for (int i = 0; i < 4; i++) begin
            chk("seq_req", 32'(imem_req), 32'h1);
            chk("seq_addr", imem_addr, 32'(i * 4));
            tick();
            chk("seq_valid", 32'(instr_valid), 32'h1);
            chk("seq_pc", instr_pc, 32'(i * 4));
            tick();
            chk("seq_gap", 32'(instr_valid), 32'h0);
        end

        // three wait cycles at 0x10
        imem_ready   = 1'b0;
        instr_accept = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("wait_addr", imem_addr, 32'h10);
            tick();
        end
        imem_ready = 1'b1;
        chk("wait_addr", imem_addr, 32'h10);
        tick();
        chk("wait_pc", instr_pc, 32'h10);
        chk("wait_instr", instruction, mem_word(32'h10));

        // decode stall in HOLD
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_req", 32'(imem_req), 32'h0);
            chk("hold_pc", instr_pc, 32'h10);
            chk("hold_instr", instruction, mem_word(32'h10));
        end
        instr_accept = 1'b1;
        imem_ready   = 1'b0;
        tick();
        chk("hold_next", imem_addr, 32'h14);
        instr_accept = 1'b0;

        // flush of a stalled fetch, last redirect wins
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        imem_ready     = 1'b1;
        tick();
        redirect_valid = 1'b0;
        imem_ready     = 1'b0;
        chk("drn_addr", imem_addr, 32'h40);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        chk("drn_hold_addr", imem_addr, 32'h40);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        chk("drn_hold_addr2", imem_addr, 32'h40);
        imem_ready = 1'b1;
        tick();
        chk("drn_valid", 32'(instr_valid), 32'h0);
        chk("drn_new_addr", imem_addr, 32'h300);
        tick();
        chk("drn_pc", instr_pc, 32'h300);

        // misaligned redirect in HOLD together with accept
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        instr_accept   = 1'b1;
        tick();
        redirect_valid = 1'b0;
        instr_accept   = 1'b0;
        chk("mis_valid", 32'(instr_valid), 32'h0);
        chk("mis_addr", imem_addr, 32'h100);
        chk("mis_flag", 32'(misalign), 32'h1);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        instr_accept = 1'b1;
        tick();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("mis_sticky", 32'(misalign), 32'h1);

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            imem_ready     = ($urandom_range(0, 2) != 0);
            instr_accept   = ($urandom_range(0, 1) != 0);
            redirect_valid = ($urandom_range(0, 5) == 0);
            redirect_pc    = $urandom;
            tick();
        end

        // asynchronous reset during a stalled fetch
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        imem_ready     = 1'b1;
        instr_accept   = 1'b1;
        tick();
        redirect_valid = 1'b0;
        imem_ready     = 1'b0;
        tick();
        chk("pre_rst_addr", imem_addr, 32'h500);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst_b_addr", imem_addr_b, 32'hBFC0_0000);
        chk("arst_b_valid", 32'(instr_valid_b), 32'h0);
        chk("arst_b_instr", instruction_b, 32'h0);
        chk("arst_b_pc", instr_pc_b, 32'h0);
        chk("arst_b_mis", 32'(misalign_b), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_b_req", 32'(imem_req_b), 32'h1);
        chk("rel_b_addr", imem_addr_b, 32'hBFC0_0000);
        chk("rel_addr", imem_addr, 32'h0);
        imem_ready   = 1'b1;
        instr_accept = 1'b0;
        tick();
        chk("rel_b_valid", 32'(instr_valid_b), 32'h1);
        chk("rel_b_pc", instr_pc_b, 32'hBFC0_0000);
        chk("rel_b_instr", instruction_b, mem_word(32'hBFC0_0000));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
